// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-source packet arbiter: FSM states and the
// round-robin "last granted" pointer.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  // Records which source finished the most recent packet.
  typedef enum logic {
    PTR_B_LAST = 1'b0,
    PTR_A_LAST = 1'b1
  } ptr_e;

endpackage

// File: rtl/mux_1toD.sv
// Two-way W-bit data selector: sel_i = 1 picks in1_i, otherwise in0_i.
module mux_1toD #(
  parameter int W = 9
) (
  input  logic         sel_i,
  input  logic [W-1:0] in1_i,
  input  logic [W-1:0] in0_i,
  output logic [W-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mux_arb_2to1.sv
// Packet-level 2:1 arbiter with a registered output beat. Ties go round-robin;
// defining MUX_ARB_FIXED_PRI_EN makes A always win ties instead.
module mux_arb_2to1
  import mux_arb_pkg::*;
#(
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic         a_last,
  input  logic [D-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic         b_last,
  input  logic [D-1:0] b_data,
  output logic         b_ready,
  output logic         out_valid,
  output logic         out_last,
  output logic [D-1:0] out_data,
  input  logic         out_ready,
  output logic         sel,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshake: a beat moves on any port exactly in a cycle where valid && ready
  // are both high at the rising edge; valid never depends on ready.

  state_e       state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic [D-1:0] out_data_q, out_data_d;
  logic         out_free;
  logic         a_xfer, b_xfer, xfer;
  logic [D:0]   sel_beat;

  assign sel       = (state_q == GRANT_A);
  assign busy      = (state_q == GRANT_A) || (state_q == GRANT_B);
  assign dbg_state = state_q;

  assign out_free = !out_valid_q || out_ready;
  assign a_ready  = (state_q == GRANT_A) && out_free;
  assign b_ready  = (state_q == GRANT_B) && out_free;
  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;
  assign xfer     = a_xfer || b_xfer;

  mux_1toD #(.W(D + 1)) u_mux (
    .sel_i (sel),
    .in1_i ({a_last, a_data}),
    .in0_i ({b_last, b_data}),
    .out_o (sel_beat)
  );

`ifdef MUX_ARB_FIXED_PRI_EN
  logic tie_grant_a;
  assign tie_grant_a = 1'b1;
`else
  ptr_e ptr_q, ptr_d;
  logic tie_grant_a;
  assign tie_grant_a = (ptr_q == PTR_B_LAST);

  always_comb begin
    ptr_d = ptr_q;
    if (a_xfer && a_last) ptr_d = PTR_A_LAST;
    if (b_xfer && b_last) ptr_d = PTR_B_LAST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PTR_B_LAST;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (a_valid && b_valid) state_d = tie_grant_a ? GRANT_A : GRANT_B;
        else if (a_valid)       state_d = GRANT_A;
        else if (b_valid)       state_d = GRANT_B;
      end
      GRANT_A: if (a_xfer && a_last) state_d = IDLE;
      GRANT_B: if (b_xfer && b_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A load wins over a drain, so a same-cycle drain+load keeps out_valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_last_d  = sel_beat[D];
      out_data_d  = sel_beat[D-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Directed bench for mux_arb_2to1 (D = 8): packets, ties, backpressure,
// interleave guard, mid-packet gap and reset abort.
module tb_mux_arb_2to1;

  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_valid = 1'b0, a_last = 1'b0;
  logic [D-1:0] a_data = '0;
  logic         b_valid = 1'b0, b_last = 1'b0;
  logic [D-1:0] b_data = '0;
  logic         out_ready = 1'b1;
  logic         a_ready, b_ready, out_valid, out_last, sel, busy;
  logic [D-1:0] out_data;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [D:0] exp_q[$];

  mux_arb_2to1 #(.D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_last    (a_last),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_last    (b_last),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every beat accepted downstream must match the next expected one
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("beat_unexpected", 32'(exp_q.size()), 32'd1);
      else                   check("beat", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
    end
  end

  // driver: offer one beat, wait (bounded) for acceptance, check the loaded output
  task automatic send_beat(input bit src_a, input logic [D-1:0] d, input logic last);
    bit done;
    done = 1'b0;
    if (src_a) begin a_valid = 1'b1; a_data = d; a_last = last; end
    else       begin b_valid = 1'b1; b_data = d; b_last = last; end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (src_a) check("other_ready_b", 32'(b_ready), 32'd0);
      else       check("other_ready_a", 32'(a_ready), 32'd0);
      if (src_a ? a_ready : b_ready) done = 1'b1;
      step();
    end
    if (!done) check("ready_timeout", 32'(done), 32'd1);
    else begin
      check("load_valid", 32'(out_valid), 32'd1);
      check("load_beat", 32'({out_last, out_data}), 32'({last, d}));
    end
  endtask

  initial begin
    // reset state
    repeat (2) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    step();

    // single A packet
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
    a_valid = 1'b1; a_data = 8'h11; #1;
    check("idle_no_ready", 32'(a_ready), 32'd0);
    send_beat(1'b1, 8'h11, 1'b0);
    send_beat(1'b1, 8'h22, 1'b0);
    send_beat(1'b1, 8'h33, 1'b1);
    a_valid = 1'b0; a_last = 1'b0;
    check("single_end_state", 32'(dbg_state), 32'd0);
    check("single_end_busy", 32'(busy), 32'd0);
    step();

    // backpressure mid-packet
    exp_q.push_back(9'h041); exp_q.push_back(9'h042);
    exp_q.push_back(9'h043); exp_q.push_back(9'h144);
    send_beat(1'b1, 8'h41, 1'b0);
    send_beat(1'b1, 8'h42, 1'b0);
    out_ready = 1'b0; a_data = 8'h43; a_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'h42);
      check("bp_a_ready", 32'(a_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    send_beat(1'b1, 8'h43, 1'b0);
    send_beat(1'b1, 8'h44, 1'b1);
    a_valid = 1'b0; a_last = 1'b0;
    step();

    // interleave guard: B waits for A's last beat, then one IDLE cycle
    exp_q.push_back(9'h051); exp_q.push_back(9'h052); exp_q.push_back(9'h053);
    exp_q.push_back(9'h154); exp_q.push_back(9'h15B);
    a_valid = 1'b1; a_data = 8'h51; a_last = 1'b0;
    step();
    b_valid = 1'b1; b_data = 8'h5B; b_last = 1'b1;
    send_beat(1'b1, 8'h51, 1'b0);
    send_beat(1'b1, 8'h52, 1'b0);
    send_beat(1'b1, 8'h53, 1'b0);
    send_beat(1'b1, 8'h54, 1'b1);
    a_valid = 1'b0; a_last = 1'b0; #1;
    check("il_bubble_state", 32'(dbg_state), 32'd0);
    check("il_bubble_b_ready", 32'(b_ready), 32'd0);
    step();
    check("il_grant_b_state", 32'(dbg_state), 32'd2);
    check("il_grant_b_ready", 32'(b_ready), 32'd1);
    send_beat(1'b0, 8'h5B, 1'b1);
    b_valid = 1'b0; b_last = 1'b0;
    step();

    // gap: A drops valid for 3 cycles mid-packet
    exp_q.push_back(9'h061); exp_q.push_back(9'h062); exp_q.push_back(9'h163);
    send_beat(1'b1, 8'h61, 1'b0);
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gap_busy", 32'(busy), 32'd1);
      check("gap_sel", 32'(sel), 32'd1);
      step();
    end
    send_beat(1'b1, 8'h62, 1'b0);
    send_beat(1'b1, 8'h63, 1'b1);
    a_valid = 1'b0; a_last = 1'b0;
    step();

    // reset abort during beat 2; beat 1 never reaches the consumer
    send_beat(1'b1, 8'h71, 1'b0);
    a_data = 8'h72; rst = 1'b1; #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_a_ready", 32'(a_ready), 32'd0);
    a_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_abort_out_valid", 32'(out_valid), 32'd0);
    end

    // tie after reset: A first, then alternation (or A only with fixed priority)
    for (int i = 0; i < 4; i++) begin
`ifdef MUX_ARB_FIXED_PRI_EN
      exp_q.push_back(9'h1AA);
`else
      exp_q.push_back((i % 2 == 0) ? 9'h1AA : 9'h1BB);
`endif
    end
    a_valid = 1'b1; a_data = 8'hAA; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'hBB; b_last = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("tie_out_valid", 32'(out_valid), 32'(k % 2 == 0));
      if (k % 2 == 1) begin
`ifdef MUX_ARB_FIXED_PRI_EN
        check("tie_sel", 32'(sel), 32'd1);
`else
        check("tie_sel", 32'(sel), 32'(k % 4 == 1));
`endif
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();
    check("final_out_valid", 32'(out_valid), 32'd0);
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_2to1.md
MUX_ARB_2TO1 -- requirements
Module: mux_arb_2to1

Interface
REQ-001 Parameter D, default 8: data width of each source and of the output.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_valid, a_last  input  1 each  source A beat valid, last beat of A's packet.
REQ-005 a_data  input  D  source A data.
REQ-006 a_ready  output  1  source A beat accepted when a_valid && a_ready.
REQ-007 b_valid, b_last  input  1 each; b_data  input  D; b_ready  output  1: source B, same rules as A.
REQ-008 out_valid, out_last  output  1 each; out_data  output  D: registered output beat.
REQ-009 out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
REQ-010 sel  output  1  current grant (1 = A, 0 = B), meaningful only when busy = 1.
REQ-011 busy  output  1  high in GRANT_A or GRANT_B.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT_A, GRANT_B.
REQ-013 In IDLE, a_valid only -> GRANT_A; b_valid only -> GRANT_B; neither -> stay in IDLE.
REQ-014 In IDLE with a_valid && b_valid, the grant SHALL go to the source not granted last (round-robin pointer).
REQ-015 Ready rule: x_ready = (state == GRANT_x) && (!out_valid || out_ready); the non-granted ready SHALL be 0 and IDLE asserts no ready.
REQ-016 On a transfer, out_data/out_last SHALL load the granted source's data/last on the next edge, with out_valid = 1 (latency 1 cycle).
REQ-017 out_valid SHALL clear on out_ready when no new transfer occurs in the same cycle; a simultaneous drain and load SHALL keep out_valid = 1 with the new beat.
REQ-018 A grant SHALL be held across all beats until a beat with x_last = 1 transfers; the state then returns to IDLE and the pointer records x.
REQ-019 There SHALL be one IDLE cycle between packets, so back-to-back packets cost one bubble cycle.
REQ-020 Held outputs SHALL stay stable while out_valid && !out_ready.
REQ-021 A dropping x_valid mid-packet SHALL keep the grant (no re-arbitration mid-packet).
REQ-022 A single-beat packet (x_last = 1 on the first beat) SHALL return to IDLE after that beat.

Reset
REQ-023 On rst: state = IDLE, pointer = "B last" (A wins the first tie), out_valid = 0, out_last = 0, out_data = 0, a_ready = b_ready = 0, busy = 0, sel = 0.
REQ-024 Reset asserted mid-packet SHALL abort the packet immediately; the partial packet is discarded and no beat is output after release until a new grant.

Configuration
REQ-025 Macro MUX_ARB_FIXED_PRI_EN defined: ties in IDLE always grant A and the pointer is unused.
REQ-026 Macro MUX_ARB_FIXED_PRI_EN undefined: round-robin per REQ-014.

Structure
REQ-027 Package mux_arb_pkg SHALL hold the state encodings (IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2) and the pointer encoding.
REQ-028 Data selection SHALL use one mux_1toD instance of width D+1 ({last, data}) driven by sel; the FSM, pointer and output register sit in mux_arb_2to1.

Verification (D = 8)
REQ-029 Single A: A sends 3 beats 0x11, 0x22, 0x33 with last on 0x33 and out_ready = 1 -> out shows 0x11, 0x22, 0x33 one cycle after each transfer, out_last on 0x33, then IDLE.
REQ-030 Tie: A and B both hold 1-beat packets continuously (A = 0xAA, B = 0xBB) -> output alternates 0xAA, 0xBB, 0xAA, ... with a bubble between each; with MUX_ARB_FIXED_PRI_EN defined, output is only 0xAA.
REQ-031 Backpressure: out_ready = 0 for 4 cycles mid-packet -> out_data is held, a_ready = 0, and no beat is lost or duplicated.
REQ-032 Interleave guard: B raises valid during A's 4-beat packet -> b_ready stays 0 until A's last beat; B is then granted after one IDLE cycle.
REQ-033 Reset abort: rst pulsed during A's beat 2 of 4 -> out_valid = 0 the next cycle, state IDLE, and the next tie grants A.
REQ-034 Gap: a_valid deasserted 3 cycles mid-packet -> busy = 1 and sel = 1 throughout, and the packet resumes intact.
